divide_unit: RTL and testbench

Multi-cycle integer divider in the execute stage; consumes the 4-bit `divideEn` field produced by instruction decode for RV64M DIV/DIVU/REM/REMU and their W variants. It accepts one operation when idle, iterates a radix-2 restoring algorithm, and returns a single-cycle `done` pulse with the RISC-V-compliant 64-bit result. Execute stalls on `!ready` or while waiting for `done`, and flushes the unit on redirect.

---
 rtl/divide_unit_if.sv | 15 +
 rtl/divide_unit.sv | 151 +++++++++++++++
 tb/tb_divide_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/divide_unit_if.sv
// Request/response bundle between execute and the divider.
// The master drives the request; the slave returns ready/done/result.
interface divide_unit_if;
  logic        valid;
  logic [3:0]  divideEn;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        ready;
  logic        done;
  logic [63:0] result;

  modport master (output valid, divideEn, a, b, flush, input ready, done, result);
  modport slave  (input valid, divideEn, a, b, flush, output ready, done, result);
endinterface

// File: rtl/divide_unit.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Optional `DIV_SPECIAL_FASTPATH_EN`: divide-by-zero/overflow skip straight to DONE.
module divide_unit (
  input  logic         clk,
  input  logic         resetn,
  divide_unit_if.slave dif
);
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, dvd_q, dvd_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                w_q, w_d, rsel_q, rsel_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic                divz_q, divz_d, ovf_q, ovf_d;

  logic                is_w, is_uns, is_rem, sa, sb, divz_in, ovf_in, accept;
  logic signed [DATA_W-1:0] ext_a, ext_b;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     pr_shift;
  logic [DATA_W+1:0]   diff;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_step, quo_step;
  logic [6:0]          last_cnt;

  // Sign fix-up plus RISC-V special-case results; W results sign-extend from bit 31.
  function automatic logic [DATA_W-1:0] fixup(
    input logic [DATA_W-1:0] quo, rem, dvd,
    input logic w, rsel, qneg, rneg, divz, ovf);
    logic [DATA_W-1:0] q, r, sel;
    q = qneg ? -quo : quo;
    r = rneg ? -rem : rem;
    if (divz)     sel = rsel ? dvd : '1;
    else if (ovf) sel = rsel ? '0 : dvd;
    else          sel = rsel ? r : q;
    return w ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction

  // Operand prep: W ops extend the low word; signed ops divide magnitudes.
  always_comb begin
    is_w    = dif.divideEn[3];
    is_rem  = dif.divideEn[1];
    is_uns  = dif.divideEn[0];
    ext_a   = is_w ? (is_uns ? {32'b0, dif.a[31:0]} : {{32{dif.a[31]}}, dif.a[31:0]}) : dif.a;
    ext_b   = is_w ? (is_uns ? {32'b0, dif.b[31:0]} : {{32{dif.b[31]}}, dif.b[31:0]}) : dif.b;
    sa      = !is_uns && ext_a[DATA_W-1];
    sb      = !is_uns && ext_b[DATA_W-1];
    mag_a   = sa ? -ext_a : ext_a;
    mag_b   = sb ? -ext_b : ext_b;
    divz_in = (ext_b == '0);
    ovf_in  = !is_uns && (ext_b == '1) &&
              (is_w ? (ext_a == 64'hFFFF_FFFF_8000_0000) : (ext_a == 64'h8000_0000_0000_0000));
    accept  = dif.valid && (state_q == IDLE) && dif.divideEn[2] && !dif.flush;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    pr_shift = {rem_q, quo_q[DATA_W-1]};
    diff     = {1'b0, pr_shift} - {2'b0, dsr_q};
    q_bit    = !diff[DATA_W+1];
    rem_step = q_bit ? diff[DATA_W-1:0] : pr_shift[DATA_W-1:0];
    quo_step = {quo_q[DATA_W-2:0], q_bit};
    last_cnt = w_q ? 7'd31 : 7'd63;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    dvd_d    = dvd_q;
    result_d = result_q;
    w_d      = w_q;
    rsel_d   = rsel_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (accept) begin
        w_d     = is_w;
        rsel_d  = is_rem;
        qneg_d  = sa ^ sb;
        rneg_d  = sa;
        divz_d  = divz_in;
        ovf_d   = ovf_in;
        dvd_d   = ext_a;
        dsr_d   = mag_b;
        rem_d   = '0;
        // W magnitudes are left-aligned so 32 steps consume exactly the low word.
        quo_d   = is_w ? {mag_a[31:0], 32'b0} : mag_a;
        cnt_d   = '0;
        state_d = RUN;
`ifdef DIV_SPECIAL_FASTPATH_EN
        if (divz_in || ovf_in) begin
          state_d  = DONE;
          result_d = fixup('0, '0, ext_a, is_w, is_rem, sa ^ sb, sa, divz_in, ovf_in);
        end
`else
`endif
      end
      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == last_cnt) begin
          state_d  = DONE;
          result_d = fixup(quo_step, rem_step, dvd_q, w_q, rsel_q, qneg_q, rneg_q, divz_q, ovf_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dsr_q  <= dsr_d;
    dvd_q  <= dvd_d;
    w_q    <= w_d;
    rsel_q <= rsel_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    divz_q <= divz_d;
    ovf_q  <= ovf_d;
  end

  assign dif.ready  = (state_q == IDLE);
  assign dif.done   = (state_q == DONE) && !dif.flush;
  assign dif.result = result_q;
endmodule

// File: tb/tb_divide_unit.sv
// Bench for divide_unit: directed vector table, abort sequences, and random ops
// checked against a plain-arithmetic RISC-V division model.
module tb_divide_unit;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  divide_unit_if dif ();
  divide_unit dut (.clk(clk), .resetn(resetn), .dif(dif.slave));

`ifdef DIV_SPECIAL_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [3:0] DIV = 4'b0100, DIVU = 4'b0101, REM = 4'b0110, REMU = 4'b0111;
  localparam logic [3:0] DIVW = 4'b1100, DIVUW = 4'b1101, REMW = 4'b1110, REMUW = 4'b1111;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics using native SV division.
  function automatic logic [63:0] ref_div(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    logic [31:0] r32;
    logic [63:0] r64;
    if (op[3]) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0) r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a[31:0];
      else if (op[0]) r32 = op[1] ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      else r32 = op[1] ? (sa32 % sb32) : (sa32 / sb32);
      return {{32{r32[31]}}, r32};
    end
    sa64 = a;
    sb64 = b;
    if (b == 64'd0) r64 = op[1] ? a : '1;
    else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) r64 = op[1] ? 64'd0 : a;
    else if (op[0]) r64 = op[1] ? (a % b) : (a / b);
    else r64 = op[1] ? (sa64 % sb64) : (sa64 / sb64);
    return r64;
  endfunction

  function automatic bit is_special(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[3])
      return (b[31:0] == 32'd0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  // Entered and left at #1 after a rising edge; on return we are in cycle 1.
  task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !dif.ready; i++) begin @(posedge clk); #1; end
    if (!dif.ready) begin
      checks++;
      failures++;
      $display("FAIL ready_wait: ready=0 required=1");
      return;
    end
    dif.valid = 1'b1; dif.divideEn = op; dif.a = a; dif.b = b;
    @(posedge clk); #1;
    dif.valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit poke);
    int lat, cyc;
    bit ok, seen, busy_bad;
    lat = (FAST && is_special(op, a, b)) ? 1 : (op[3] ? 33 : 65);
    seen = 1'b0; busy_bad = 1'b0;
    start_op(op, a, b, ok);
    if (!ok) return;
    for (cyc = 1; cyc <= 200; cyc++) begin
      if (dif.done) begin seen = 1'b1; break; end
      if (dif.ready) busy_bad = 1'b1;
      if (poke && cyc == 5) begin
        dif.valid = 1'b1; dif.divideEn = DIV; dif.a = 64'd999; dif.b = 64'd3;
      end else dif.valid = 1'b0;
      @(posedge clk); #1;
    end
    dif.valid = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: op=%b a=%h b=%h no done within 200 cycles", op, a, b);
      return;
    end
    check($sformatf("result op=%b a=%h b=%h", op, a, b), dif.result, exp);
    check($sformatf("done_cycle op=%b", op), 64'(cyc), 64'(lat));
    check($sformatf("busy_ready_low op=%b", op), {63'd0, busy_bad}, 64'd0);
    @(posedge clk); #1;
    check($sformatf("after_done {done,ready} op=%b", op), {62'd0, dif.done, dif.ready}, 64'd1);
  endtask

  initial begin
    bit ok, bad;
    logic [3:0] op;
    logic [63:0] a, b;

    vecs.push_back('{DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{DIVU,  64'd100, 64'd7, 64'd14});
    vecs.push_back('{REMU,  64'd100, 64'd7, 64'd2});
    vecs.push_back('{DIVUW, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 64'd14});
    vecs.push_back('{DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{REMW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0});
    vecs.push_back('{REM,   64'h1234, 64'd0, 64'h1234});
    vecs.push_back('{DIV,   64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
    vecs.push_back('{REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
    vecs.push_back('{REMUW, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{REMW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});

    dif.valid = 1'b0; dif.divideEn = 4'd0; dif.a = '0; dif.b = '0; dif.flush = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset {done,ready}", {62'd0, dif.done, dif.ready}, 64'd1);
    check("reset result", dif.result, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

    // Busy unit ignores a second request.
    run_op(DIVU, 64'd100, 64'd7, 64'd14, 1'b1);

    // Illegal opcode (bit 2 clear) is ignored.
    dif.valid = 1'b1; dif.divideEn = 4'b0001; dif.a = 64'd5; dif.b = 64'd1;
    @(posedge clk); #1;
    dif.valid = 1'b0;
    check("illegal_op ready", {63'd0, dif.ready}, 64'd1);

    // Flush and valid together in IDLE: nothing accepted.
    dif.valid = 1'b1; dif.flush = 1'b1; dif.divideEn = DIVU; dif.a = 64'd50; dif.b = 64'd5;
    @(posedge clk); #1;
    dif.valid = 1'b0; dif.flush = 1'b0;
    check("flush_idle ready", {63'd0, dif.ready}, 64'd1);

    // Flush in cycle 20.
    start_op(DIVU, 64'd100, 64'd7, ok);
    bad = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (dif.done || dif.ready) bad = 1'b1;
      @(posedge clk); #1;
    end
    dif.flush = 1'b1;
    @(posedge clk); #1;
    dif.flush = 1'b0;
    check("flush busy_before", {63'd0, bad}, 64'd0);
    check("flush cycle21 {done,ready}", {62'd0, dif.done, dif.ready}, 64'd1);
    bad = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (dif.done || !dif.ready) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("flush no_late_done", {63'd0, bad}, 64'd0);
    run_op(REMU, 64'd100, 64'd7, 64'd2, 1'b0);

    // Reset in cycle 30 of a run.
    start_op(DIVU, 64'd1000, 64'd7, ok);
    for (int c = 1; c < 30; c++) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midreset {done,ready}", {62'd0, dif.done, dif.ready}, 64'd1);
    check("midreset result", dif.result, 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (dif.done || !dif.ready) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("midreset no_late_done", {63'd0, bad}, 64'd0);
    run_op(DIVW, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = {$urandom_range(0, 1) == 1, 1'b1, 2'($urandom_range(0, 3))};
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: begin a = 64'h8000_0000_8000_0000; b = '1; end
        3: b = 64'($urandom_range(1, 1000));
        4: b = b >> $urandom_range(1, 62);
        default: ;
      endcase
      run_op(op, a, b, ref_div(op, a, b), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
